// File: rtl/fetch_align_unit.sv
// Instruction fetch stage: owns the PC, aligns 16/32-bit instructions and expands RVC to 32 bits.
// Optional macro RVC_EN enables compressed-instruction support; default build is 32-bit only.
module fetch_align_unit #(
    parameter int unsigned       ADDR_W   = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_INST = 32'h0000_0033
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic [31:0]       inst_word,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_link,
    output logic              inst_valid,
    output logic              is_compressed,
    output logic              illegal,
    output logic              halted
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next, pc_out_next, link_next;
    logic [ADDR_W-1:0] pc_step, pc_seq, redirect_target;
    logic [31:0]       inst_next, dec_inst;
    logic              valid_next, comp_next, ill_next, halted_next;
    logic              dec_comp, dec_ill, dec_halt;

`ifdef RVC_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

    typedef struct packed {
        logic        ill;
        logic [31:0] inst;
    } rvc_exp_t;

    function automatic rvc_exp_t expand_rvc(input logic [15:0] c);
        rvc_exp_t    r;
        logic [2:0]  rdp, rs1p;
        logic [4:0]  rd, rs2;
        logic [11:0] imm6;
        logic [9:0]  uimm_spn;
        logic [6:0]  uimm_lw;
        logic [11:1] j_off;
        logic [8:1]  b_off;
        r.ill    = 1'b0;
        r.inst   = NOP_INST;
        rdp      = c[4:2];
        rs1p     = c[9:7];
        rd       = c[11:7];
        rs2      = c[6:2];
        imm6     = {{7{c[12]}}, c[6:2]};
        uimm_spn = {c[10:7], c[12:11], c[5], c[6], 2'b00};
        uimm_lw  = {c[5], c[12:10], c[6], 2'b00};
        j_off    = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
        b_off    = {c[12], c[6:5], c[2], c[11:10], c[4:3]};
        case (c[1:0])
            2'b00: case (c[15:13])
                3'b000: if (uimm_spn == '0) r.ill = 1'b1;
                        else r.inst = {2'b00, uimm_spn, 5'd2, 3'b000, 2'b01, rdp, 7'b0010011};
                3'b010: r.inst = {5'b0, uimm_lw, 2'b01, rs1p, 3'b010, 2'b01, rdp, 7'b0000011};
                3'b110: r.inst = {5'b0, uimm_lw[6:5], 2'b01, rdp, 2'b01, rs1p, 3'b010,
                                  uimm_lw[4:0], 7'b0100011};
                default: r.ill = 1'b1;
            endcase
            2'b01: case (c[15:13])
                3'b000: r.inst = {imm6, rd, 3'b000, rd, 7'b0010011};
                3'b010: r.inst = {imm6, 5'd0, 3'b000, rd, 7'b0010011};
                // rd==2 is c.addi16sp, which is outside the supported subset
                3'b011: if (rd == 5'd2 || imm6 == '0) r.ill = 1'b1;
                        else r.inst = {{8{c[12]}}, imm6, rd, 7'b0110111};
                3'b100: if (c[11:10] == 2'b10)
                            r.inst = {imm6, 2'b01, rs1p, 3'b111, 2'b01, rs1p, 7'b0010011};
                        else r.ill = 1'b1;
                3'b101: r.inst = {c[12], j_off[10:1], j_off[11], {8{c[12]}}, 5'd0, 7'b1101111};
                3'b110, 3'b111:
                        r.inst = {c[12], c[12], c[12], b_off[8:5], 5'd0, 2'b01, rs1p,
                                  2'b00, c[13], b_off[4:1], c[12], 7'b1100011};
                default: r.ill = 1'b1;
            endcase
            2'b10: case (c[15:13])
                3'b000: if (c[12]) r.ill = 1'b1;
                        else r.inst = {7'b0, c[6:2], rd, 3'b001, rd, 7'b0010011};
                3'b100: if (rs2 == '0) begin
                            if (rd == '0) r.ill = 1'b1;
                            else r.inst = {12'b0, rd, 3'b000, 4'b0, c[12], 7'b1100111};
                        end else begin
                            r.inst = {7'b0, rs2, (c[12] ? rd : 5'd0), 3'b000, rd, 7'b0110011};
                        end
                default: r.ill = 1'b1;
            endcase
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    rvc_exp_t rvc_exp;
    assign rvc_exp = expand_rvc(inst_word[15:0]);

    always_comb begin
        dec_halt = (inst_word[15:0] == 16'h0000);
        dec_comp = (inst_word[1:0] != 2'b11);
        dec_ill  = dec_comp & rvc_exp.ill;
        dec_inst = dec_comp ? rvc_exp.inst : inst_word;
    end
`else
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    always_comb begin
        dec_halt = (inst_word == 32'h0);
        dec_comp = 1'b0;
        dec_ill  = (inst_word[1:0] != 2'b11);
        dec_inst = dec_ill ? NOP_INST : inst_word;
    end
`endif

    assign fetch_addr      = pc;
    assign pc_step         = dec_comp ? ADDR_W'(2) : ADDR_W'(4);
    assign pc_seq          = pc + pc_step;
    assign redirect_target = redirect_pc & ALIGN_MASK;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path can infer a latch.
        state_next  = state;
        pc_next     = pc;
        inst_next   = inst_out;
        pc_out_next = pc_out;
        link_next   = pc_link;
        valid_next  = inst_valid;
        comp_next   = is_compressed;
        ill_next    = illegal;
        halted_next = halted;
        case (state)
            BOOT: begin
                state_next = RUN;
                if (redirect) pc_next = redirect_target;
            end
            RUN: begin
                if (redirect) begin
                    pc_next    = redirect_target;
                    valid_next = 1'b0;
                    inst_next  = NOP_INST;
                    comp_next  = 1'b0;
                    ill_next   = 1'b0;
                end else if (!stall) begin
                    if (dec_halt) begin
                        state_next  = HALT;
                        halted_next = 1'b1;
                        valid_next  = 1'b0;
                        inst_next   = NOP_INST;
                        comp_next   = 1'b0;
                        ill_next    = 1'b0;
                    end else begin
                        pc_next     = pc_seq;
                        inst_next   = dec_inst;
                        pc_out_next = pc;
                        link_next   = pc_seq;
                        valid_next  = 1'b1;
                        comp_next   = dec_comp;
                        ill_next    = dec_ill;
                    end
                end
            end
            HALT:    ;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            inst_out      <= NOP_INST;
            pc_out        <= RESET_PC;
            pc_link       <= RESET_PC;
            inst_valid    <= 1'b0;
            is_compressed <= 1'b0;
            illegal       <= 1'b0;
            halted        <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            inst_out      <= inst_next;
            pc_out        <= pc_out_next;
            pc_link       <= link_next;
            inst_valid    <= valid_next;
            is_compressed <= comp_next;
            illegal       <= ill_next;
            halted        <= halted_next;
        end
    end
endmodule

// File: tb/tb_fetch_align_unit.sv
// Scoreboard bench for fetch_align_unit: directed memory images, expected stream queued up front.
module tb_fetch_align_unit;
    localparam int          AW  = 6;
    localparam logic [31:0] NOP = 32'h0000_0033;
`ifdef RVC_EN
    localparam logic [AW-1:0] WRAP_PC = 6'd62;
`else
    localparam logic [AW-1:0] WRAP_PC = 6'd60;
`endif

    typedef struct {
        logic [31:0]   inst;
        logic [AW-1:0] pc;
        logic [AW-1:0] link;
        logic          comp;
        logic          ill;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, stall, redirect;
    logic [AW-1:0] redirect_pc, fetch_addr, pc_out, pc_link;
    logic [31:0]   inst_word, inst_out;
    logic          inst_valid, is_compressed, illegal, halted;
    logic          last_stall = 1'b0;

    logic [7:0] mem [0:63];
    exp_t       exp_q [$];
    exp_t       e;
    int         n_tests = 0;
    int         n_fail  = 0;

    fetch_align_unit #(.ADDR_W(AW), .RESET_PC(6'd0), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .fetch_addr(fetch_addr), .inst_word(inst_word),
        .inst_out(inst_out), .pc_out(pc_out), .pc_link(pc_link),
        .inst_valid(inst_valid), .is_compressed(is_compressed),
        .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    assign inst_word = {mem[fetch_addr + 6'd3], mem[fetch_addr + 6'd2],
                        mem[fetch_addr + 6'd1], mem[fetch_addr]};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [AW-1:0] pc,
                        input logic [AW-1:0] link, input logic comp, input logic ill);
        exp_t x;
        x.inst = inst; x.pc = pc; x.link = link; x.comp = comp; x.ill = ill;
        exp_q.push_back(x);
    endtask

    task automatic put_half(input int addr, input logic [15:0] h);
        mem[addr]     = h[7:0];
        mem[addr + 1] = h[15:8];
    endtask

    task automatic put_word(input int addr, input logic [31:0] w);
        put_half(addr, w[15:0]);
        put_half(addr + 2, w[31:16]);
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!halted && n < 40) begin
            tick();
            n++;
        end
        check("halt_reached", halted, 1);
    endtask

    // Monitor: a new instruction is presented when inst_valid is high after a non-stalled edge.
    always @(posedge clk) last_stall <= stall;

    always @(negedge clk) begin
        if (inst_valid === 1'b1 && !last_stall) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_inst: got pc_out %0d inst %h, expected no instruction",
                         pc_out, inst_out);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("inst_out@%0d", e.pc), inst_out, e.inst);
                check($sformatf("pc_out@%0d", e.pc), pc_out, e.pc);
                check($sformatf("pc_link@%0d", e.pc), pc_link, e.link);
                check($sformatf("is_compressed@%0d", e.pc), is_compressed, e.comp);
                check($sformatf("illegal@%0d", e.pc), illegal, e.ill);
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int a = 0; a < 16; a += 4) put_word(a, NOP);
        put_word(60, NOP);
`ifdef RVC_EN
        put_half(16, 16'h4004); put_half(18, 16'h9422); put_half(20, 16'h0000);
        put_half(24, 16'h6001); put_half(26, 16'h428D); put_half(28, 16'h8082);
        put_half(30, 16'h0040); put_half(32, 16'h0000); put_half(62, 16'h0001);
`else
        put_word(16, 32'h0000_4004); put_word(20, 32'h0);
        put_word(24, 32'h0030_0293); put_word(28, 32'h0000_8067); put_word(32, 32'h0);
`endif

        for (int a = 0; a < 16; a += 4) push(NOP, 6'(a), 6'(a + 4), 1'b0, 1'b0);
`ifdef RVC_EN
        push(32'h0004_2483, 6'd16, 6'd18, 1'b1, 1'b0);
        push(32'h0084_0433, 6'd18, 6'd20, 1'b1, 1'b0);
`else
        push(NOP, 6'd16, 6'd20, 1'b0, 1'b1);
`endif

        tick(); tick();
        check("rst_fetch_addr", fetch_addr, 0);
        check("rst_inst_out", inst_out, NOP);
        check("rst_pc_out", pc_out, 0);
        check("rst_pc_link", pc_link, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_is_compressed", is_compressed, 0);
        check("rst_illegal", illegal, 0);
        check("rst_halted", halted, 0);
        rst = 1'b0;
        tick();
        check("boot_valid", inst_valid, 0);
        check("boot_fetch", fetch_addr, 0);
        tick();
        check("first_valid", inst_valid, 1);
        wait_halt();
        check("halt_fetch", fetch_addr, 20);
        check("halt_valid", inst_valid, 0);
        check("halt_inst_out", inst_out, NOP);
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            redirect = ~i[0] | i[1];
            redirect_pc = 6'd40;
            tick();
            check($sformatf("halt_hold%0d", i), {halted, inst_valid, fetch_addr}, {1'b1, 1'b0, 6'd20});
        end
        check("drain_phase1", exp_q.size(), 0);

        rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 6'd40;
        tick();
        check("midrst_halted", halted, 0);
        check("midrst_fetch", fetch_addr, 0);
        check("midrst_valid", inst_valid, 0);
        check("midrst_inst_out", inst_out, NOP);
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;

        push(NOP, 6'd0, 6'd4, 1'b0, 1'b0);
        push(NOP, 6'd8, 6'd12, 1'b0, 1'b0);
`ifdef RVC_EN
        push(32'h0000_0013, 6'd62, 6'd0, 1'b1, 1'b0);
        push(NOP, 6'd0, 6'd4, 1'b0, 1'b0);
        push(NOP, 6'd24, 6'd26, 1'b1, 1'b1);
        push(32'h0030_0293, 6'd26, 6'd28, 1'b1, 1'b0);
        push(32'h0000_8067, 6'd28, 6'd30, 1'b1, 1'b0);
        push(32'h0041_0413, 6'd30, 6'd32, 1'b1, 1'b0);
`else
        push(NOP, 6'd60, 6'd0, 1'b0, 1'b0);
        push(NOP, 6'd0, 6'd4, 1'b0, 1'b0);
        push(32'h0030_0293, 6'd24, 6'd28, 1'b0, 1'b0);
        push(32'h0000_8067, 6'd28, 6'd32, 1'b0, 1'b0);
`endif
        tick();
        tick();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 6'd9;
        tick();
        check("redir_fetch", fetch_addr, 8);
        check("redir_bubble", inst_valid, 0);
        stall = 1'b0; redirect = 1'b0;
        tick();
        check("redir_target_valid", inst_valid, 1);
        redirect = 1'b1; redirect_pc = 6'd63;
        tick();
        check("wrap_redirect", fetch_addr, WRAP_PC);
        redirect = 1'b0;
        tick();
        check("wrap_fetch", fetch_addr, 0);
        tick();
        redirect = 1'b1; redirect_pc = 6'd25;
        tick();
        check("redir24_fetch", fetch_addr, 24);
        redirect = 1'b0;
        wait_halt();
        check("halt2_fetch", fetch_addr, 32);
        tick();
        check("drain_phase2", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_align_unit.md
# fetch_align_unit

Instruction fetch stage feeding the IF/ID pipeline register. Owns the program counter and drives the instruction-side address of the unified byte-addressed memory. Consumes the 32-bit little-endian word returned at that address, detects 16-bit compressed instructions, and expands the supported subset to 32-bit equivalents. The PC advances by 2 or 4, so decode and execute only ever see 32-bit instructions.

## Interface
- ADDR_W, 6: byte-address width; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0: PC value loaded on reset.
- NOP_INST, 32'h00000033: bubble instruction (add x0,x0,x0).

Ports:
- clk  in  1: single clock, all state updates on rising edge.
- rst  in  1: synchronous, active-high reset.
- stall  in  1: hazard unit hold; freezes PC and outputs.
- redirect  in  1: branch/jump taken; load redirect_pc.
- redirect_pc  in  ADDR_W: target byte address.
- fetch_addr  out  ADDR_W: to memory addr (instruction phase); equals PC register.
- inst_word  in  32: memory data_out for fetch_addr.
- inst_out  out  32: registered 32-bit instruction to IF/ID.
- pc_out  out  ADDR_W: address of inst_out.
- pc_link  out  ADDR_W: pc_out+2 if compressed else pc_out+4 (jal/jalr link value).
- inst_valid  out  1: inst_out is a real instruction.
- is_compressed  out  1: inst_out was expanded from 16 bits.
- illegal  out  1: unsupported/illegal encoding fetched.
- halted  out  1: fetch stopped on all-zero instruction.

## Operation
- States: BOOT, RUN, HALT.
  - BOOT is entered on rst. It lasts one cycle, captures nothing, and goes to RUN.
  - RUN goes to HALT when a halt word is fetched.
  - HALT exits only on rst.
- Each RUN edge without stall or redirect:
  - Decode inst_word.
  - Register the result into inst_out/pc_out/pc_link/is_compressed/illegal and set inst_valid=1.
  - PC <= PC+2 for a compressed instruction, PC+4 otherwise.
- Compressed means inst_word[1:0]!=2'b11.
- Expanded subset:
  - C0: c.addi4spn, c.lw, c.sw.
  - C1: c.nop/c.addi, c.li, c.lui, c.andi, c.j, c.beqz, c.bnez.
  - C2: c.slli, c.mv, c.add, c.jr, c.jalr.
- Illegal handling: any other compressed encoding (reserved zero-immediate forms included) gives inst_out=NOP_INST, illegal=1, inst_valid=1, PC+2.
- Halt word: inst_word[15:0]==0. It gives inst_valid=0, inst_out=NOP_INST, halted=1, PC frozen.
- Redirect takes priority over stall:
  - PC <= redirect_pc with bit0 cleared.
  - inst_valid=0 and inst_out=NOP_INST for that edge.
  - Redirect also applies in BOOT. It is ignored in HALT.
- Stall without redirect: PC, state and all outputs hold.
- Address arithmetic is modulo 2^ADDR_W. PC 62 with a compressed instruction wraps to 0. PC 62 with a 32-bit instruction wraps to 2. pc_link wraps the same way.

## Timing
- Reset values: PC=RESET_PC, fetch_addr=RESET_PC, inst_out=NOP_INST, pc_out=RESET_PC, pc_link=RESET_PC, inst_valid=0, is_compressed=0, illegal=0, halted=0.
- Contract: inst_word is stable and valid for fetch_addr at the rising edge ending the cycle in which fetch_addr is presented (combinational memory read).
- Latency: 1 cycle, address to registered instruction.
- Throughput: 1 instruction per cycle.
- First valid instruction appears 2 edges after rst deasserts (BOOT edge, then RUN capture).
- Redirect costs exactly one bubble cycle. The target instruction is valid on the following edge.
- rst asserted mid-stream: reset values apply on the next edge regardless of stall or redirect.

## Configuration
- RVC_EN defined: compressed detection and expansion as above; redirect clears bit0; halt on inst_word[15:0]==0.
- RVC_EN undefined:
  - Every word is treated as 32-bit and PC always advances by 4.
  - Words with [1:0]!=2'b11 flag illegal=1 and output NOP_INST.
  - is_compressed is tied to 0.
  - Redirect clears bits[1:0].
  - Halt on inst_word==0.

## Test plan
- Reset then free-run on add x0 words at 0,4,8,12 -> inst_valid first high on the 2nd edge after reset; pc_out sequence 0,4,8,12; inst_out=32'h00000033.
- RVC_EN, halfwords 0x4004 at 16 and 0x9422 at 18 -> inst_out 32'h00042483 (lw x9,0(x8)) with pc_link 18, then 32'h00840433 (add x8,x8,x8) with pc_link 20; is_compressed=1 both times.
- RVC_EN, halfword 0x0000 at 20 -> halted=1, inst_valid=0, fetch_addr stays 20 for 10 cycles; stall and redirect have no effect; rst clears halted.
- Redirect to 9 while stall=1 at PC 4 -> next edge PC=8 and inst_valid=0; following edge pc_out=8 and inst_valid=1.
- Compressed halfword 0x0001 (c.nop) at PC 62 -> pc_out 62, pc_link 0, next fetch_addr 0; halfword 0x6001 (c.lui reserved zero imm) -> illegal=1, inst_out NOP_INST.
- RVC_EN undefined, word 0x00004004 -> illegal=1, PC advances by 4, is_compressed=0.
